// File: rtl/md_issue.sv
// ----------------------------------------------------------------------------
// md_issue
//
// Sits between E-stage decode and the multiply/divide unit. Requests are
// mult/div or mthi/mtlo. They are queued in a small circular FIFO and handed
// to the unit one at a time with its start/busy handshake. The block also
// produces the HI/LO read interlock, so the pipeline stalls only when the
// queue is full or when a HI/LO read would see a stale value.
//
// Build option:
//   MD_BYPASS_EN - when defined, a legal request that arrives while the
//                  queue, the FSM and the unit are all quiet goes straight
//                  to the md_* registers at the same edge. No FIFO entry is
//                  written in that case.
//
// Parameters:
//   DEPTH  FIFO entries (1..8)
//   CW     occupancy counter width, must hold 0..DEPTH
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid             E-stage request strobe
//   req_mdop              0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
//   req_wen               01 mtlo, 10 mthi, other values mean none
//   req_op1, req_op2      rs / rt values
//   req_ready             queue not full
//   mf_req                E-stage instruction reads HI or LO
//   mf_stall              stall for a HI/LO read hazard (combinational)
//   md_start              registered one-cycle start pulse to the unit
//   md_mdop, md_wen       registered opcode / direct HI,LO write enable
//   md_op1, md_op2        registered operands
//   md_busy               unit busy
//   hilo_pending          an accepted operation has not yet retired
//
// FSM states:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | may pop the head; a write entry pulses md_wen and stays here
//   ST_LAUNCH | md_start high for exactly one cycle
//   ST_WAIT   | operands held until the unit drops md_busy
// ----------------------------------------------------------------------------
module md_issue #(
    parameter int DEPTH = 2,
    parameter int CW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_mdop,
    input  logic [1:0]  req_wen,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic        req_ready,
    input  logic        mf_req,
    output logic        mf_stall,
    output logic        md_start,
    output logic [2:0]  md_mdop,
    output logic [1:0]  md_wen,
    output logic [31:0] md_op1,
    output logic [31:0] md_op2,
    input  logic        md_busy,
    output logic        hilo_pending
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 3 + 2 + 32 + 32;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t        r_state;
    logic [EW-1:0] r_mem [0:(1<<PW)-1];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          r_md_start;
    logic [2:0]    r_md_mdop;
    logic [1:0]    r_md_wen;
    logic [31:0]   r_md_op1;
    logic [31:0]   r_md_op2;

    logic          w_is_comp;
    logic          w_is_wr;
    logic          w_legal;
    logic [EW-1:0] w_req_entry;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;
    logic          w_disp;
    logic [EW-1:0] w_disp_entry;
    logic [2:0]    w_d_mdop;
    logic [1:0]    w_d_wen;
    logic [31:0]   w_d_op1;
    logic [31:0]   w_d_op2;

    // Compute entries drop req_wen so the dispatch side can tell the two
    // kinds apart purely from mdop.
    assign w_is_comp   = (req_mdop != 3'd0) && (req_mdop <= 3'd4);
    assign w_is_wr     = (req_mdop == 3'd0) && ((req_wen == 2'b01) || (req_wen == 2'b10));
    assign w_legal     = w_is_comp || w_is_wr;
    assign w_req_entry = {req_mdop, (w_is_comp ? 2'b00 : req_wen), req_op1, req_op2};

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL);
    assign w_pop   = (r_state == ST_IDLE) && !w_empty && !md_busy;

`ifdef MD_BYPASS_EN
    assign w_bypass = req_valid && w_legal && w_empty && (r_state == ST_IDLE)
                      && !md_busy && (r_md_wen == 2'b00);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = req_valid && !w_full && w_legal && !w_bypass;

    // Bypass only fires with an empty queue, so it never competes with a pop.
    assign w_disp       = w_pop || w_bypass;
    assign w_disp_entry = w_bypass ? w_req_entry : r_mem[r_head];
    assign {w_d_mdop, w_d_wen, w_d_op1, w_d_op2} = w_disp_entry;

    assign req_ready    = !w_full;
    assign hilo_pending = !w_empty || (r_state != ST_IDLE) || md_busy || (r_md_wen != 2'b00);
    assign mf_stall     = mf_req && hilo_pending;

    assign md_start = r_md_start;
    assign md_mdop  = r_md_mdop;
    assign md_wen   = r_md_wen;
    assign md_op1   = r_md_op1;
    assign md_op2   = r_md_op2;

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_tail] <= w_req_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_md_start <= 1'b0;
            r_md_mdop  <= '0;
            r_md_wen   <= '0;
            r_md_op1   <= '0;
            r_md_op2   <= '0;
        end else begin
            if (w_push) begin
                r_tail <= (r_tail == LAST) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= (r_head == LAST) ? '0 : r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                ST_IDLE: begin
                    r_md_start <= 1'b0;
                    r_md_wen   <= 2'b00;
                    r_md_mdop  <= '0;
                    r_md_op1   <= '0;
                    r_md_op2   <= '0;
                    if (w_disp) begin
                        if (w_d_mdop != 3'd0) begin
                            r_md_start <= 1'b1;
                            r_md_mdop  <= w_d_mdop;
                            r_md_op1   <= w_d_op1;
                            r_md_op2   <= w_d_op2;
                            r_state    <= ST_LAUNCH;
                        end else begin
                            // HI/LO direct write: one-cycle md_wen pulse, no start.
                            r_md_wen <= w_d_wen;
                            r_md_op1 <= w_d_op1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    // The unit only raises busy after it sees start, so leave
                    // unconditionally rather than sampling busy here.
                    r_md_start <= 1'b0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!md_busy) begin
                        r_state   <= ST_IDLE;
                        r_md_mdop <= '0;
                        r_md_op1  <= '0;
                        r_md_op2  <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
